// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning a shared N:1 single-bit mux path, with break-before-make gap.
// Optional forced release after TIMEOUT hold cycles: define RRARB_TIMEOUT_EN.
module rr_mux_arbiter #(
    parameter int N       = 16,
    parameter int SELW    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            done,
    input  logic [N-1:0]    x,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] s,
    output logic            valid,
    output logic            f,
    output logic            tmo
);

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    state_t          state;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] pick;
    logic [SELW-1:0] idx;
    logic            any_req;
    logic            rel;
    logic            expire;

    // Scan from ptr upward with natural SELW-bit wrap; descending loop lets the lowest offset win.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ptr + SELW'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    assign any_req = |req;
    assign rel     = done | ~req[s];
    assign f       = valid & x[s];

`ifdef RRARB_TIMEOUT_EN
    logic [7:0] hold;
    assign expire = (hold == 8'(TIMEOUT - 1));
`else
    assign expire = 1'b0;
    assign tmo    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            s     <= '0;
            valid <= 1'b0;
            ptr   <= '0;
`ifdef RRARB_TIMEOUT_EN
            hold  <= '0;
            tmo   <= 1'b0;
`endif
        end else begin
`ifdef RRARB_TIMEOUT_EN
            tmo <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= {{(N-1){1'b0}}, 1'b1} << pick;
                        s     <= pick;
                        valid <= 1'b1;
                        state <= OWN;
`ifdef RRARB_TIMEOUT_EN
                        hold  <= '0;
`endif
                    end
                end
                OWN: begin
                    if (rel || expire) begin
                        grant <= '0;
                        valid <= 1'b0;
                        ptr   <= s + 1'b1;
                        state <= GAP;
`ifdef RRARB_TIMEOUT_EN
                        tmo   <= expire & ~rel;
`endif
                    end
`ifdef RRARB_TIMEOUT_EN
                    else begin
                        hold <= hold + 8'd1;
                    end
`endif
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: driver queues expected owners, monitor checks each new grant.
module tb_rr_mux_arbiter;
    localparam int N    = 16;
    localparam int SELW = 4;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic            done  = 1'b0;
    logic [N-1:0]    req   = '0;
    logic [N-1:0]    x     = '0;
    logic [N-1:0]    grant;
    logic [SELW-1:0] s;
    logic            valid;
    logic            f;
    logic            tmo;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    logic vprev = 1'b0;

    rr_mux_arbiter #(.N(N), .SELW(SELW), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done), .x(x),
        .grant(grant), .s(s), .valid(valid), .f(f), .tmo(tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_level(input logic lvl, input int max, output int n);
        n = 0;
        while (valid !== lvl && n < max) begin
            @(negedge clk);
            n++;
        end
        if (valid !== lvl) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: valid=%0b expected %0b within %0d cycles", valid, lvl, max);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each new grant.
    always @(posedge clk) begin
        int e;
        #1;
        chk("inv_onehot", 32'($onehot0(grant)), 1);
        chk("inv_grant_s", 32'(valid ? (grant == (N'(1) << s)) : (grant == '0)), 1);
        if (!valid) chk("f_idle", 32'(f), 0);
`ifndef RRARB_TIMEOUT_EN
        chk("tmo_zero", 32'(tmo), 0);
`endif
        if (valid && !vprev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got s=%0d expected no grant", s);
            end else begin
                e = exp_q.pop_front();
                chk("grant_s", 32'(s), 32'(e));
                chk("grant_vec", 32'(grant), 32'(N'(1) << e));
                chk("f_sel", 32'(f), 32'(x[e]));
            end
        end
        vprev = valid;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset and idle
        x = 16'hFFFF;
        tick(3);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_outputs", 32'({grant, s, valid, f}), 0);
        end

        // Single requester 0
        x = 16'h0001;
        exp_q.push_back(0);
        req = 16'h0001;
        tick();
        chk("single_valid", 32'(valid), 1);
        chk("single_f", 32'(f), 1);
        done = 1'b1;
        req  = '0;
        tick();
        done = 1'b0;
        chk("single_gap", 32'({grant, valid}), 0);
        chk("gap_s_hold", 32'(s), 0);
        tick(2);

        // Full round robin 0..15,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        x = 16'hAAAA;
        for (int i = 0; i < 16; i++) exp_q.push_back(i);
        exp_q.push_back(0);
        req = '1;
        wait_level(1'b1, 5, n);
        for (int k = 0; k < 17; k++) begin
            done = 1'b1;
            tick();
            done = 1'b0;
            chk("rr_release", 32'(valid), 0);
            if (k < 16) begin
                wait_level(1'b1, 8, n);
                chk("rr_gap_cycles", 32'(n), 2);
            end
        end
        req = '0;
        tick(3);

        // Wrap fairness: owner 13, then 15 over 3, then 3
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.push_back(13);
        exp_q.push_back(15);
        exp_q.push_back(3);
        req = 16'h2000;
        wait_level(1'b1, 5, n);
        done = 1'b1;
        req  = 16'h8008;
        tick();
        done = 1'b0;
        wait_level(1'b1, 8, n);
        req = 16'h0008;
        tick();
        chk("withdraw_release", 32'(valid), 0);
        wait_level(1'b1, 8, n);
        done = 1'b1;
        req  = '0;
        tick();
        done = 1'b0;
        tick(2);

        // Reset while owner 7 holds
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.push_back(7);
        req = 16'h0080;
        wait_level(1'b1, 5, n);
        tick(2);
        reset = 1'b1;
        tick();
        chk("reset_mid_own", 32'({grant, s, valid}), 0);
        exp_q.push_back(7);
        reset = 1'b0;
        wait_level(1'b1, 5, n);
        done = 1'b1;
        req  = '0;
        tick();
        done = 1'b0;
        tick(2);

        // Long hold by requester 5 with 6 also waiting
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.push_back(5);
        req = 16'h0060;
        wait_level(1'b1, 5, n);
`ifdef RRARB_TIMEOUT_EN
        exp_q.push_back(6);
        n = 0;
        while (valid && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_hold", 32'(n), 15);
        chk("tmo_pulse", 32'(tmo), 1);
        tick();
        chk("tmo_once", 32'(tmo), 0);
        wait_level(1'b1, 8, n);
        done = 1'b1;
        req  = '0;
        tick();
        done = 1'b0;
`else
        tick(20);
        chk("hold_valid", 32'(valid), 1);
        chk("hold_s", 32'(s), 5);
        chk("hold_tmo", 32'(tmo), 0);
        done = 1'b1;
        req  = '0;
        tick();
        done = 1'b0;
`endif
        tick(3);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
